modular_mult_radix: RTL and testbench
=====================================

# modular_mult_radix

Parametrised successor to the `modular_mult` datapath: computes Z = (A·B) mod N for arbitrary WIDTH-bit operands with a start/done/busy handshake, synchronous reset, and a configurable number of operand bits retired per clock. It first pre-reduces B modulo N, then runs an interleaved shift-add-subtract multiply over A, MSB first. It is the modular-multiply engine beneath the modular-exponentiation controller and the primary power-trace target of the side-channel experiments.

## Interface
- WIDTH, 32: operand/result width in bits.
- DIGIT_BITS, 1: operand bits processed per clock (unrolled radix-2 steps). WIDTH % DIGIT_BITS must be 0; otherwise elaboration fails.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- A  in  WIDTH  multiplicand, any value (may be ≥ N)
- B  in  WIDTH  multiplier, any value (may be ≥ N)
- N  in  WIDTH  modulus
- Z  out  WIDTH  result, valid when done=1, held until next accept
- done  out  1  one-cycle completion pulse
- busy  out  1  high from accept until the done cycle inclusive
- err  out  1  set with done when N==0; held until next accept

## Operation
- States: IDLE, REDUCE, MULT, DONE. Let C = WIDTH/DIGIT_BITS.
- IDLE: if start=1, register A, B, N internally, clear err, set busy. Next state: REDUCE, MULT (fast path, see Configuration), or DONE (N==0 fast path). Later changes on A/B/N are ignored until the next accept.
- REDUCE (C cycles): restoring remainder over B, MSB first. Per bit: rem = 2·rem + b_i; if rem ≥ N then rem −= N. rem is WIDTH+1 bits. Result Br = B mod N.
- MULT (C cycles): accumulator R starts at 0 and is WIDTH+2 bits. Per bit of A, MSB first: R = 2·R + a_i·Br, then up to two conditional subtractions of N. Invariant: R < N after every step.
- DONE (1 cycle): Z ← R[WIDTH-1:0], done=1, busy=1. Next state: IDLE. start is ignored in DONE.
- N==0: Z=0, err=1, done pulses. N==1: Z=0, err=0 (normal path).
- Step counter is log2(C)+1 bits and wraps to 0 on every state entry.

## Timing
- Reset, including mid-operation: at the next edge, state=IDLE, Z=0, done=0, busy=0, err=0. Any in-flight operation is discarded.
- Accept at edge t, full path: done=1 during the cycle after edge t+2C+1; busy is high for 2C+1 cycles.
- Fast path (B < N, no macro): done after edge t+C+1.
- start held high continuously: a new accept occurs on the first IDLE cycle after done, giving a back-to-back period of latency+1 cycles.
- Z and err change only at DONE entry or reset; at all other times they hold.

## Configuration
- MODMULT_CONST_TIME_EN defined: REDUCE always runs for C cycles, even when B < N. N==0 also traverses REDUCE and MULT, with the datapath running on N treated as all-ones, and reports err only in DONE. Latency is always 2C+1, independent of the data.
- Not defined: REDUCE is skipped when B < N, so latency is C+1. N==0 goes IDLE→DONE, with done one cycle after accept. Latency therefore depends on the data, which is intentional for leakage studies.

## Test plan
- WIDTH=32, DIGIT_BITS=1, A=57, B=18, N=9 → Z=0, err=0. done at accept+65 cycles with the macro; accept+65 without it, since B ≥ N.
- A=350, B=27, N=19 → Z=7. A=7775, B=714, N=779 → Z=196. A=3115, B=2117, N=911 → Z=637. Check busy is high for the full latency.
- A=54, B=33, N=68 → Z=14. done at accept+33 without the macro and accept+65 with it.
- N=0, A=5, B=5 → err=1, Z=0, single done pulse. Then A=43, B=66, N=9 → err clears on accept, Z=3.
- Assert rst for 1 cycle mid-MULT → next cycle busy=0, done=0, Z=0. A subsequent operation (A=4535, B=4518, N=459) → Z=(4535·4518) mod 459. The bench computes the expected value with a 64-bit model.
- DIGIT_BITS=4, WIDTH=32 plus 1000 random operands with N ≠ 0, checked against a behavioural mod → all match, and full-path latency = 17 cycles.

Source files
------------

// File: rtl/modular_mult_radix.sv
// modular_mult_radix: Z = (A*B) mod N via B pre-reduction followed by an
// interleaved MSB-first shift-add-subtract multiply over A, retiring
// DIGIT_BITS operand bits per clock.
//
// Parameters:
//   WIDTH      operand/result width (must be a multiple of DIGIT_BITS)
//   DIGIT_BITS radix-2 steps unrolled per clock
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, accepted only while busy=0
//   A, B, N         multiplicand, multiplier, modulus (captured on accept)
//   Z               result, held until next DONE entry or reset
//   done            one-cycle completion pulse
//   busy            high from accept through the done cycle
//   err             set with done when N==0, cleared on accept
// Build option:
//   MODMULT_CONST_TIME_EN  data-independent latency (REDUCE always runs,
//                          N==0 traverses the datapath with N = all-ones)
module modular_mult_radix #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIGIT_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] Z,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int unsigned C  = WIDTH / DIGIT_BITS;
  localparam int unsigned CW = $clog2(C) + 1;

  if ((WIDTH % DIGIT_BITS) != 0) begin : g_bad_cfg
    $error("modular_mult_radix: WIDTH must be a multiple of DIGIT_BITS");
  end

  typedef enum logic [1:0] {IDLE, REDUCE, MULT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH+1:0] r_q, r_d;
  logic [WIDTH-1:0] z_d;
  logic             done_d, busy_d, err_d;

  logic [WIDTH-1:0] n_eff;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] b_nx, a_nx;
  logic [WIDTH+1:0] r_nx;

  // Modulus seen by the datapath
`ifdef MODMULT_CONST_TIME_EN
  assign n_eff = (n_q == '0) ? '1 : n_q;
`else
  assign n_eff = n_q;
`endif

  // DIGIT_BITS restoring-remainder steps over B; rem < N holds between steps
  always_comb begin : reduce_step
    rem_nx = rem_q;
    b_nx   = b_q;
    for (int i = 0; i < int'(DIGIT_BITS); i++) begin
      rem_nx = {rem_nx[WIDTH-1:0], b_nx[WIDTH-1]};
      b_nx   = b_nx << 1;
      if (rem_nx >= {1'b0, n_eff}) rem_nx = rem_nx - {1'b0, n_eff};
    end
  end

  // DIGIT_BITS interleaved multiply steps; 2R + Br < 3N so two subtracts suffice
  always_comb begin : mult_step
    r_nx = r_q;
    a_nx = a_q;
    for (int i = 0; i < int'(DIGIT_BITS); i++) begin
      r_nx = {r_nx[WIDTH:0], 1'b0}
           + (a_nx[WIDTH-1] ? {2'b00, rem_q[WIDTH-1:0]} : (WIDTH+2)'(0));
      a_nx = a_nx << 1;
      if (r_nx >= {2'b00, n_eff}) r_nx = r_nx - {2'b00, n_eff};
      if (r_nx >= {2'b00, n_eff}) r_nx = r_nx - {2'b00, n_eff};
    end
  end

  // Next-state and registered-output logic
  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    rem_d   = rem_q;
    r_d     = r_q;
    z_d     = Z;
    done_d  = 1'b0;
    busy_d  = busy;
    err_d   = err;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          a_d    = A;
          b_d    = B;
          n_d    = N;
          rem_d  = '0;
          r_d    = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
`ifdef MODMULT_CONST_TIME_EN
          state_d = REDUCE;
`else
          if (N == '0) begin
            state_d = DONE;
            z_d     = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else if (B < N) begin
            // B is already reduced; feed it straight to the multiplier
            state_d = MULT;
            rem_d   = {1'b0, B};
          end else begin
            state_d = REDUCE;
          end
`endif
        end
      end

      REDUCE: begin
        rem_d = rem_nx;
        b_d   = b_nx;
        if (cnt_q == CW'(C - 1)) begin
          state_d = MULT;
          cnt_d   = '0;
        end
      end

      MULT: begin
        r_d = r_nx;
        a_d = a_nx;
        if (cnt_q == CW'(C - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
          z_d     = (n_q == '0) ? '0 : r_nx[WIDTH-1:0];
          err_d   = (n_q == '0);
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      r_q     <= '0;
      Z       <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      Z       <= z_d;
      done    <= done_d;
      busy    <= busy_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_modular_mult_radix.sv
// Self-checking bench for modular_mult_radix: directed vectors on a radix-2
// instance plus a randomized sweep on a DIGIT_BITS=4 instance.
module tb_modular_mult_radix;

  localparam int C1 = 32;
  localparam int C4 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4;
  logic [31:0] A, B, N, A4, B4, N4;
  logic [31:0] Z, Z4;
  logic        done, busy, err, done4, busy4, err4;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prev_z;

  always #5 clk = ~clk;

  modular_mult_radix #(.WIDTH(32), .DIGIT_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .N(N),
    .Z(Z), .done(done), .busy(busy), .err(err)
  );

  modular_mult_radix #(.WIDTH(32), .DIGIT_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .N(N4),
    .Z(Z4), .done(done4), .busy(busy4), .err(err4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b, input logic [31:0] n, input int c);
`ifdef MODMULT_CONST_TIME_EN
    return 2 * c + 1;
`else
    if (n == 32'd0) return 1;
    if (b < n) return c + 1;
    return 2 * c + 1;
`endif
  endfunction

  // One transaction on the radix-2 instance with full handshake checks
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] n, input logic [31:0] ez, input logic eerr);
    int k;
    int busy_low;
    int elat;
    elat = exp_lat(b, n, C1);
    @(negedge clk);
    A = a; B = b; N = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // inputs after accept must not affect the result
    A = $urandom; B = $urandom; N = $urandom;
    if (elat > 1) begin
      check({tag, "_err_clear"}, 64'(err), 64'd0);
      check({tag, "_z_hold"}, 64'(Z), 64'(prev_z));
    end
    k = 1;
    busy_low = 0;
    while (!done && k < 200) begin
      if (!busy) busy_low++;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(elat));
    check({tag, "_busy_gap"}, 64'(busy_low), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    check({tag, "_z"}, 64'(Z), 64'(ez));
    check({tag, "_err"}, 64'(err), 64'(eerr));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    check({tag, "_z_held"}, 64'(Z), 64'(ez));
    prev_z = ez;
  endtask

  initial begin
    logic [31:0] ra, rb, rn;
    logic [63:0] model;
    int k, p;

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    A = '0; B = '0; N = '0; A4 = '0; B4 = '0; N4 = '0;
    prev_z = '0;
    repeat (3) @(negedge clk);
    check("reset_z", 64'(Z), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    rst = 1'b0;

    run_op("v57_18_9",    32'd57,   32'd18,   32'd9,   32'd0,   1'b0);
    run_op("v350_27_19",  32'd350,  32'd27,   32'd19,  32'd7,   1'b0);
    run_op("v7775",       32'd7775, 32'd714,  32'd779, 32'd196, 1'b0);
    run_op("v3115",       32'd3115, 32'd2117, 32'd911, 32'd637, 1'b0);
    run_op("v54_33_68",   32'd54,   32'd33,   32'd68,  32'd14,  1'b0);
    run_op("n_zero",      32'd5,    32'd5,    32'd0,   32'd0,   1'b1);
    run_op("after_nzero", 32'd43,   32'd66,   32'd9,   32'd3,   1'b0);
    run_op("n_one",       32'd12345, 32'd999, 32'd1,   32'd0,   1'b0);
    run_op("max_ops",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd16, 1'b0);

    // Back-to-back with start held: done period is latency + 1
    @(negedge clk);
    A = 32'd350; B = 32'd27; N = 32'd19; start = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 200);
    check("b2b_z_first", 64'(Z), 64'd7);
    p = 0;
    do begin @(negedge clk); p++; end while (!done && p < 200);
    start = 1'b0;
    check("b2b_period", 64'(p), 64'(exp_lat(32'd27, 32'd19, C1) + 1));
    check("b2b_z_second", 64'(Z), 64'd7);
    @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);
    prev_z = 32'd7;

    // Reset in the middle of MULT discards the operation
    @(negedge clk);
    A = 32'd3115; B = 32'd2117; N = 32'd911; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (C1 + 4) @(negedge clk);
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_z", 64'(Z), 64'd0);
    check("rst_mid_err", 64'(err), 64'd0);
    prev_z = '0;
    model = (64'd4535 * 64'd4518) % 64'd459;
    run_op("post_rst", 32'd4535, 32'd4518, 32'd459, 32'(model), 1'b0);

    // Randomized sweep on the radix-16 instance against a 64-bit model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rn = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rn == 32'd0) rn = 32'd1;
      model = (64'(ra) * 64'(rb)) % 64'(rn);
      @(negedge clk);
      A4 = ra; B4 = rb; N4 = rn; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      k = 1;
      while (!done4 && k < 100) begin @(negedge clk); k++; end
      check("r4_latency", 64'(k), 64'(exp_lat(rb, rn, C4)));
      check("r4_z", 64'(Z4), model);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
